pll_lock_reset_sequencer: RTL and testbench
===========================================

// Module: pll_lock_reset_sequencer
// PURPOSE
//  Consumes the EHXPLLL LOCK output and generates the design's reset tree in the clock domain it runs on.
//  - Synchronises the asynchronous lock signal.
//  - Requires lock to be stable, then releases per-stage active-low resets in a fixed order with fixed gaps.
//  - Re-asserts all resets on lock loss and counts lock-loss events for debug readback.
//  - Sits directly behind the PLL wrapper, clocked by the 33.75 MHz CPU/video clock.
// PARAMETERS
//  SYNC_STAGES    2    flops in the lock synchroniser (>=2)
//  STABLE_CYCLES  256  consecutive synchronised-lock cycles required before first release (>=2)
//  STAGE_GAP      16   cycles between consecutive stage releases (>=1)
//  NUM_STAGES     3    number of reset outputs; stage 0 released first (>=1)
//  CNT_W          8    width of lock-loss counter
// PORTS
//  clk              in   1           system clock (PLL output domain)
//  resetn           in   1           synchronous, active-low reset
//  pll_locked       in   1           raw PLL LOCK, asynchronous to clk
//  soft_reset_req   in   1           1-cycle pulse: re-run release sequence without a lock loss
//  stage_resetn     out  NUM_STAGES  per-stage active-low resets, bit i = stage i
//  ready            out  1           all stages released
//  lock_loss_count  out  CNT_W       saturating count of lock losses after any stage release
// BEHAVIOUR
//  Reset and clocking:
//  - One clock; reset is synchronous and active-low.
//  - resetn=0: synchroniser flops=0, state=WAIT_LOCK, stage_resetn=0, ready=0, lock_loss_count=0, counters=0.
//  Synchroniser:
//  - locked_s = pll_locked delayed by SYNC_STAGES flops.
//  - Only locked_s feeds the FSM; the raw input is never used directly.
//  States:
//  - WAIT_LOCK:
//    - Outputs held in reset.
//    - locked_s=1 -> STABILIZE; stable counter loaded with 1.
//  - STABILIZE:
//    - locked_s=0 -> WAIT_LOCK.
//    - Else the counter increments.
//    - When count reaches STABLE_CYCLES -> RELEASE; the same edge sets stage_resetn[0]=1 and idx=1, gap=0.
//  - RELEASE:
//    - Gap counter increments each cycle.
//    - On reaching STAGE_GAP: stage_resetn[idx]=1, idx++, gap cleared.
//    - The edge releasing stage NUM_STAGES-1 also sets ready=1 and enters RUN.
//    - If NUM_STAGES=1, the STABILIZE exit goes straight to RUN with ready=1.
//  - RUN:
//    - Steady state; all outputs released.
//  Timing contract:
//  - T0 = first edge at which WAIT_LOCK samples locked_s=1.
//  - stage i rises at T0+STABLE_CYCLES+i*STAGE_GAP.
//  - ready rises with the last stage.
//  - Released stages stay released; bits only rise in index order.
//  Lock loss:
//  - In STABILIZE/RELEASE/RUN, locked_s=0 -> next edge: all stage_resetn=0, ready=0, state=WAIT_LOCK.
//  - lock_loss_count increments (saturates at 2^CNT_W-1) only if at least one stage was released.
//  Soft reset:
//  - soft_reset_req=1 in RUN with locked_s=1 -> next edge: all stage_resetn=0, ready=0, state=STABILIZE, counter=1.
//  - Does not count as a lock loss.
//  - Ignored in any other state.
//  Simultaneous events:
//  - Lock loss together with soft_reset_req: lock loss wins and is counted.
//  - resetn=0 overrides everything, at any point mid-sequence.
//  Glitches:
//  - A lock dropout shorter than one clk cycle may be missed by the synchroniser; that is acceptable.
//  - Any sampled 0 restarts the full STABLE_CYCLES window.
//  Outputs:
//  - All outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//  Shared package pll_reset_pkg:
//  - State encoding localparams: WAIT_LOCK, STABILIZE, RELEASE, RUN (2-bit).
//  - Default STABLE_CYCLES/STAGE_GAP constants shared with the top level and testbench.
//  Sub-module sync_ff_chain:
//  - Parameterised SYNC_STAGES flop chain.
//  - Reused for other async inputs (buttons, external IRQs).
//  Local logic:
//  - Counter widths are $clog2-derived locally.
//  - One FSM plus stable/gap/idx counters in this module.
// TESTING
//  1. Defaults; resetn low 4 cycles, pll_locked rises at cycle 10
//     -> stage_resetn 3'b001, 3'b011, 3'b111 at T0+256, T0+272, T0+288, where T0 = cycle 12.
//     -> ready rises at T0+288; lock_loss_count=0.
//  2. pll_locked dropped for 3 cycles at T0+100 (during STABILIZE)
//     -> no stage released; sequence restarts from the new T0.
//     -> lock_loss_count stays 0.
//  3. In RUN, drop pll_locked
//     -> SYNC_STAGES+1 cycles later stage_resetn=000 and ready=0; lock_loss_count=1.
//     -> After relock, full sequence repeats.
//  4. soft_reset_req pulse in RUN
//     -> next edge all resets asserted, then re-release at +256/+272/+288; count unchanged.
//     -> Same pulse issued in STABILIZE is ignored.
//  5. Lock loss on the same edge as soft_reset_req; CNT_W=2 with 5 lock losses
//     -> the coincident loss is counted; counter saturates at 3.
//  6. resetn=0 asserted mid-RELEASE (after stage 0 released)
//     -> next edge all outputs 0, count 0; sequence restarts cleanly after resetn=1.

Source files
------------

// File: rtl/pll_reset_pkg.sv
// Shared state encoding and default timing constants for the PLL lock reset sequencer.
package pll_reset_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 256;
    localparam int DEF_STAGE_GAP     = 16;
    localparam int DEF_NUM_STAGES    = 3;
    localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/sync_ff_chain.sv
// Plain flop chain for bringing an asynchronous level into the clk domain.
module sync_ff_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_sequencer.sv
// Waits for a stable PLL lock, then releases per-stage resets in order with fixed gaps;
// any lock loss pulls every stage back into reset and is counted once a stage was out.
module pll_lock_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int STAGE_GAP     = DEF_STAGE_GAP,
    parameter int NUM_STAGES    = DEF_NUM_STAGES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  pll_locked,
    input  logic                  soft_reset_req,
    output logic [NUM_STAGES-1:0] stage_resetn,
    output logic                  ready,
    output logic [CNT_W-1:0]      lock_loss_count
);

    localparam int STB_W = $clog2(STABLE_CYCLES + 1);
    localparam int GAP_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int IDX_W = $clog2(NUM_STAGES + 1);

    logic                  locked_s;
    state_t                state, state_n;
    logic [STB_W-1:0]      stable_cnt, stable_cnt_n;
    logic [GAP_W-1:0]      gap_cnt, gap_cnt_n;
    logic [IDX_W-1:0]      idx, idx_n;
    logic [NUM_STAGES-1:0] stage_n;
    logic                  ready_n;
    logic [CNT_W-1:0]      count_n;

    sync_ff_chain #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (pll_locked),
        .q      (locked_s)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state           <= WAIT_LOCK;
            stable_cnt      <= '0;
            gap_cnt         <= '0;
            idx             <= '0;
            stage_resetn    <= '0;
            ready           <= 1'b0;
            lock_loss_count <= '0;
        end else begin
            state           <= state_n;
            stable_cnt      <= stable_cnt_n;
            gap_cnt         <= gap_cnt_n;
            idx             <= idx_n;
            stage_resetn    <= stage_n;
            ready           <= ready_n;
            lock_loss_count <= count_n;
        end
    end

    always_comb begin
        state_n      = state;
        stable_cnt_n = stable_cnt;
        gap_cnt_n    = gap_cnt;
        idx_n        = idx;
        stage_n      = stage_resetn;
        ready_n      = ready;
        count_n      = lock_loss_count;

        if (state != WAIT_LOCK && !locked_s) begin
            // Stages release in index order, so bit 0 tells whether anything was out of reset.
            state_n      = WAIT_LOCK;
            stage_n      = '0;
            ready_n      = 1'b0;
            stable_cnt_n = '0;
            gap_cnt_n    = '0;
            idx_n        = '0;
            if (stage_resetn[0] && lock_loss_count != {CNT_W{1'b1}}) begin
                count_n = lock_loss_count + CNT_W'(1);
            end
        end else begin
            case (state)
                WAIT_LOCK: begin
                    stage_n = '0;
                    ready_n = 1'b0;
                    if (locked_s) begin
                        state_n      = STABILIZE;
                        stable_cnt_n = STB_W'(1);
                    end
                end
                STABILIZE: begin
                    if (stable_cnt == STB_W'(STABLE_CYCLES)) begin
                        stage_n[0] = 1'b1;
                        idx_n      = IDX_W'(1);
                        gap_cnt_n  = '0;
                        if (NUM_STAGES == 1) begin
                            ready_n = 1'b1;
                            state_n = RUN;
                        end else begin
                            state_n = RELEASE;
                        end
                    end else begin
                        stable_cnt_n = stable_cnt + STB_W'(1);
                    end
                end
                RELEASE: begin
                    if (gap_cnt == GAP_W'(STAGE_GAP - 1)) begin
                        for (int i = 0; i < NUM_STAGES; i++) begin
                            if (idx == IDX_W'(i)) stage_n[i] = 1'b1;
                        end
                        idx_n     = idx + IDX_W'(1);
                        gap_cnt_n = '0;
                        if (idx == IDX_W'(NUM_STAGES - 1)) begin
                            ready_n = 1'b1;
                            state_n = RUN;
                        end
                    end else begin
                        gap_cnt_n = gap_cnt + GAP_W'(1);
                    end
                end
                RUN: begin
                    if (soft_reset_req) begin
                        state_n      = STABILIZE;
                        stable_cnt_n = STB_W'(1);
                        stage_n      = '0;
                        ready_n      = 1'b0;
                        idx_n        = '0;
                        gap_cnt_n    = '0;
                    end
                end
                default: state_n = WAIT_LOCK;
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// Directed bench for the PLL lock reset sequencer: release timing, lock loss, soft reset, saturation.
module tb_pll_lock_reset_sequencer;
    import pll_reset_pkg::*;

    logic       clk;
    logic       resetn;
    logic       pll_locked;
    logic       soft_reset_req;
    logic [2:0] stage_resetn;
    logic       ready;
    logic [1:0] lock_loss_count;

    int total;
    int bad;
    int cyc;
    int t0;
    int s;

    pll_lock_reset_sequencer #(
        .SYNC_STAGES   (DEF_SYNC_STAGES),
        .STABLE_CYCLES (DEF_STABLE_CYCLES),
        .STAGE_GAP     (DEF_STAGE_GAP),
        .NUM_STAGES    (3),
        .CNT_W         (2)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .pll_locked      (pll_locked),
        .soft_reset_req  (soft_reset_req),
        .stage_resetn    (stage_resetn),
        .ready           (ready),
        .lock_loss_count (lock_loss_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic check_outs(input string tag, input logic [2:0] stg, input logic rdy);
        check({tag, ".stage"}, {29'd0, stage_resetn}, {29'd0, stg});
        check({tag, ".ready"}, {31'd0, ready}, {31'd0, rdy});
    endtask

    task automatic do_sequence(input int t, input string tag);
        step_to(t + 255); check_outs({tag, "@255"}, 3'b000, 1'b0);
        step_to(t + 256); check_outs({tag, "@256"}, 3'b001, 1'b0);
        step_to(t + 271); check_outs({tag, "@271"}, 3'b001, 1'b0);
        step_to(t + 272); check_outs({tag, "@272"}, 3'b011, 1'b0);
        step_to(t + 287); check_outs({tag, "@287"}, 3'b011, 1'b0);
        step_to(t + 288); check_outs({tag, "@288"}, 3'b111, 1'b1);
    endtask

    task automatic relock(output int t);
        pll_locked = 1'b1;
        t = cyc + 3;
    endtask

    task automatic lose_lock(input logic with_soft, input int exp_cnt, input string tag);
        int c;
        c = cyc;
        pll_locked = 1'b0;
        step_to(c + 2);
        check_outs({tag, ".held"}, 3'b111, 1'b1);
        if (with_soft) soft_reset_req = 1'b1;
        step_to(c + 3);
        soft_reset_req = 1'b0;
        check_outs({tag, ".drop"}, 3'b000, 1'b0);
        check({tag, ".count"}, {30'd0, lock_loss_count}, exp_cnt);
    endtask

    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        resetn = 1'b0;
        pll_locked = 1'b0;
        soft_reset_req = 1'b0;

        step_to(4);
        check_outs("reset", 3'b000, 1'b0);
        check("reset.count", {30'd0, lock_loss_count}, 0);
        resetn = 1'b1;

        // first lock: raw lock rises before edge 10, FSM sees it at edge 12
        step_to(9);
        relock(t0);
        check("t0", t0, 12);
        do_sequence(t0, "seq1");
        check("seq1.count", {30'd0, lock_loss_count}, 0);

        // lock loss in RUN is counted; relock repeats the sequence
        lose_lock(1'b0, 1, "loss1");
        relock(t0);

        // short dropout during STABILIZE restarts the window, not counted
        step_to(t0 + 100);
        pll_locked = 1'b0;
        step_to(t0 + 103);
        check_outs("glitch", 3'b000, 1'b0);
        pll_locked = 1'b1;
        t0 = cyc + 3;
        step_to(t0 + 200);
        check_outs("glitch.mid", 3'b000, 1'b0);
        do_sequence(t0, "seq2");
        check("seq2.count", {30'd0, lock_loss_count}, 1);

        // soft reset in RUN, second pulse in STABILIZE ignored
        step_to(cyc + 5);
        soft_reset_req = 1'b1;
        s = cyc + 1;
        step_to(s);
        soft_reset_req = 1'b0;
        check_outs("soft", 3'b000, 1'b0);
        check("soft.count", {30'd0, lock_loss_count}, 1);
        step_to(s + 50);
        soft_reset_req = 1'b1;
        step_to(s + 51);
        soft_reset_req = 1'b0;
        check_outs("soft.ign", 3'b000, 1'b0);
        do_sequence(s, "seq3");
        check("seq3.count", {30'd0, lock_loss_count}, 1);

        // lock loss coincident with soft reset: loss wins and is counted
        lose_lock(1'b1, 2, "loss2");

        // further losses saturate the 2-bit counter at 3
        for (int k = 0; k < 3; k++) begin
            relock(t0);
            step_to(t0 + 288);
            check_outs("sat.run", 3'b111, 1'b1);
            lose_lock(1'b0, 3, "sat");
        end

        // resetn mid-RELEASE clears everything, then a clean restart
        relock(t0);
        step_to(t0 + 261);
        check_outs("mid", 3'b001, 1'b0);
        resetn = 1'b0;
        step_to(cyc + 1);
        check_outs("mid.rst", 3'b000, 1'b0);
        check("mid.count", {30'd0, lock_loss_count}, 0);
        resetn = 1'b1;
        t0 = cyc + 3;
        do_sequence(t0, "seq4");
        check("seq4.count", {30'd0, lock_loss_count}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
